pixel_array_ctrl: RTL
=====================

PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

Interface
REQ-001 ERASE_CYCLES, 5, cycles ERASE is held high.
REQ-002 EXPOSE_CYCLES, 255, cycles EXPOSE is held high.
REQ-003 RAMP_STEPS, 255, RAMP rising edges issued per conversion (1..255).
REQ-004 READ_CYCLES, 2, cycles READ0/READ1 is held high before capture (>=1).
REQ-005 CLK  in  1  single clock; all logic rising-edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 START  in  1  frame request, sampled only in IDLE and at frame end.
REQ-008 VBN  out  1  bias enable to array.
REQ-009 RAMP  out  1  ADC ramp step strobe to array.
REQ-010 RESET  out  1  active-high array reset.
REQ-011 ERASE / EXPOSE / CONVERT  out  1 each  array phase controls.
REQ-012 READ0 / READ1  out  1 each  row-pair read selects.
REQ-013 DATA_IN1 / DATA_IN2  in  8 each  array pixel data buses.
REQ-014 OUT_VALID  out  1  readout word valid.
REQ-015 OUT_READY  in  1  downstream accepts word.
REQ-016 OUT_ROW  out  1  0 = READ0 pair, 1 = READ1 pair.
REQ-017 OUT_DATA  out  16  {DATA_IN2, DATA_IN1}.
REQ-018 BUSY  out  1  high in every state except IDLE.
REQ-019 FRAME_DONE  out  1  one-cycle pulse on final word transfer.

Function
REQ-020 FSM states SHALL be IDLE, ARST, ERASE, EXPOSE, CONVERT, READ0, OUT0, READ1, OUT1; all outputs registered.
REQ-021 IDLE: START=1 -> ARST next cycle; START=0 -> stay.
REQ-022 ARST SHALL last exactly 1 cycle with RESET=1, then ERASE.
REQ-023 ERASE/EXPOSE SHALL assert their output for exactly ERASE_CYCLES/EXPOSE_CYCLES cycles, then advance; one shared down-counter, width 9 bits.
REQ-024 CONVERT SHALL last 2*RAMP_STEPS cycles with CONVERT=1; RAMP = bit 0 of cycle index (0 on first cycle), giving exactly RAMP_STEPS rising edges; RAMP=0 on exit.
REQ-025 READ0 SHALL hold READ0=1 for READ_CYCLES cycles; on last cycle capture {DATA_IN2,DATA_IN1} into OUT_DATA, OUT_ROW=0, enter OUT0 with READ0=0.
REQ-026 OUT0/OUT1: OUT_VALID=1; transfer on OUT_VALID&OUT_READY; OUT_DATA/OUT_ROW SHALL remain stable until transfer; no next phase before transfer.
REQ-027 After OUT0 transfer -> READ1, identical to REQ-025 with READ1, OUT_ROW=1, then OUT1.
REQ-028 OUT1 transfer: FRAME_DONE=1 for that cycle's successor; START=1 -> ARST (back-to-back frames), else IDLE.
REQ-029 START outside IDLE/frame end SHALL be ignored, not queued.
REQ-030 At most one of ERASE, EXPOSE, CONVERT, READ0, READ1, RESET high in any cycle; VBN=1 whenever RESET_N=1.

Reset
REQ-031 RESET_N low SHALL immediately force IDLE, counters 0, RESET=1, VBN/RAMP/ERASE/EXPOSE/CONVERT/READ0/READ1/OUT_VALID/BUSY/FRAME_DONE=0, OUT_DATA=0, OUT_ROW=0; RESET returns 0 on the first CLK edge after release.
REQ-032 Reset mid-frame (any state) SHALL abort; in-flight OUT_DATA discarded, no FRAME_DONE.

Structure
REQ-033 State enum and default cycle constants SHALL live in shared package pixel_ctrl_pkg.
REQ-034 Single flat module; no sub-module required.

Verification
REQ-035 Default params, 1-cycle START -> RESET 1 cycle, ERASE 5, EXPOSE 255, CONVERT 510 with 255 RAMP rises, READ0 2 cycles; BUSY high throughout.
REQ-036 DATA_IN1=0x12, DATA_IN2=0x34 during READ0; 0xAB/0xCD during READ1; OUT_READY=1 -> OUT_DATA 0x3412 row 0, then 0xCDAB row 1, FRAME_DONE one pulse.
REQ-037 OUT_READY=0 for 10 cycles in OUT0 -> OUT_VALID, OUT_DATA, OUT_ROW stable, READ1 stays 0; transfer on first ready cycle.
REQ-038 RESET_N low at CONVERT cycle 100 -> all outputs to reset values same cycle, RESET=1; after release IDLE, no FRAME_DONE.
REQ-039 START pulsed during EXPOSE ignored; START held high -> OUT1 transfer followed directly by ARST.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// pixel_ctrl_pkg
//   Shared definitions for the pixel array controller: the frame FSM state
//   encoding, default phase lengths and the width of the shared phase counter.
package pixel_ctrl_pkg;

    // Width of the shared phase down-counter (covers 2*255-1 = 509).
    localparam int unsigned CNT_W = 9;

    // Default phase lengths, in clock cycles / ramp steps.
    localparam int unsigned DEF_ERASE_CYCLES  = 5;
    localparam int unsigned DEF_EXPOSE_CYCLES = 255;
    localparam int unsigned DEF_RAMP_STEPS    = 255;
    localparam int unsigned DEF_READ_CYCLES   = 2;

    typedef enum logic [3:0] {
        IDLE,
        ARST,
        ERASE,
        EXPOSE,
        CONVERT,
        READ0,
        OUT0,
        READ1,
        OUT1
    } pixel_state_t;

endpackage

// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl
//   Frame sequencer for a pixel array: array reset, erase, exposure, ramp ADC
//   conversion, then readout of two row-pair words through a valid/ready port.
//
// Ports
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   start               frame request (sampled in IDLE and at frame end only)
//   vbn                 array bias enable
//   ramp                ADC ramp step strobe
//   reset               active-high array reset
//   erase/expose/convert array phase controls
//   read0/read1         row-pair read selects
//   data_in1/data_in2   array pixel data buses
//   out_valid/out_ready readout handshake
//   out_row             0 = READ0 pair, 1 = READ1 pair
//   out_data            {data_in2, data_in1} captured at end of read phase
//   busy                high in every state except IDLE
//   frame_done          one-cycle pulse after the final word transfer
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned ERASE_CYCLES  = DEF_ERASE_CYCLES,
    parameter int unsigned EXPOSE_CYCLES = DEF_EXPOSE_CYCLES,
    parameter int unsigned RAMP_STEPS    = DEF_RAMP_STEPS,
    parameter int unsigned READ_CYCLES   = DEF_READ_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        vbn,
    output logic        ramp,
    output logic        reset,
    output logic        erase,
    output logic        expose,
    output logic        convert,
    output logic        read0,
    output logic        read1,
    input  logic [7:0]  data_in1,
    input  logic [7:0]  data_in2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_row,
    output logic [15:0] out_data,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] ERASE_LOAD   = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXPOSE_LOAD  = CNT_W'(EXPOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONVERT_LOAD = CNT_W'(2 * RAMP_STEPS - 1);
    localparam logic [CNT_W-1:0] READ_LOAD    = CNT_W'(READ_CYCLES - 1);

    pixel_state_t     state;
    logic [CNT_W-1:0] cnt;

    // Every output is a register updated together with the state, so each
    // transition below also sets the outputs for the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            vbn        <= 1'b0;
            ramp       <= 1'b0;
            reset      <= 1'b1;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read0      <= 1'b0;
            read1      <= 1'b0;
            out_valid  <= 1'b0;
            out_row    <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vbn        <= 1'b1;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    reset <= 1'b0;
                    if (start) begin
                        state <= ARST;
                        reset <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                ARST: begin
                    state <= ERASE;
                    reset <= 1'b0;
                    erase <= 1'b1;
                    cnt   <= ERASE_LOAD;
                end

                ERASE: begin
                    if (cnt == '0) begin
                        state  <= EXPOSE;
                        erase  <= 1'b0;
                        expose <= 1'b1;
                        cnt    <= EXPOSE_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                EXPOSE: begin
                    if (cnt == '0) begin
                        state   <= CONVERT;
                        expose  <= 1'b0;
                        convert <= 1'b1;
                        ramp    <= 1'b0;
                        cnt     <= CONVERT_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // ramp tracks bit 0 of the cycle index: it starts low and
                // toggles each cycle, giving one rising edge per step pair.
                CONVERT: begin
                    if (cnt == '0) begin
                        state   <= READ0;
                        convert <= 1'b0;
                        ramp    <= 1'b0;
                        read0   <= 1'b1;
                        cnt     <= READ_LOAD;
                    end else begin
                        ramp <= ~ramp;
                        cnt  <= cnt - 1'b1;
                    end
                end

                READ0: begin
                    if (cnt == '0) begin
                        state     <= OUT0;
                        read0     <= 1'b0;
                        out_data  <= {data_in2, data_in1};
                        out_row   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                OUT0: begin
                    if (out_ready) begin
                        state     <= READ1;
                        out_valid <= 1'b0;
                        read1     <= 1'b1;
                        cnt       <= READ_LOAD;
                    end
                end

                READ1: begin
                    if (cnt == '0) begin
                        state     <= OUT1;
                        read1     <= 1'b0;
                        out_data  <= {data_in2, data_in1};
                        out_row   <= 1'b1;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                OUT1: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        if (start) begin
                            state <= ARST;
                            reset <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    ramp      <= 1'b0;
                    reset     <= 1'b0;
                    erase     <= 1'b0;
                    expose    <= 1'b0;
                    convert   <= 1'b0;
                    read0     <= 1'b0;
                    read1     <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
